// File: rtl/tow_referee.sv
// Two-button tug-of-war referee: a single lit LED is pulled toward the left or
// right end by button presses, and the first player to reach their end wins.
module tow_referee #(
    parameter int BLANK_CYCLES   = 16,
    parameter int LOCKOUT_CYCLES = 4,
    parameter int FLASH_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbr,
    input  logic       pbl,
    output logic [6:0] led_out,
    output logic [1:0] winner,
    output logic       ready
);

    typedef enum logic [2:0] {
        RST_SHOW = 3'd0,
        BLANK    = 3'd1,
        PLAY     = 3'd2,
        WIN_L    = 3'd3,
        WIN_R    = 3'd4
    } state_t;

    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);
    localparam logic [7:0] LOCK_LOAD  = 8'(LOCKOUT_CYCLES);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_CYCLES - 1);
    localparam logic [2:0] POS_START  = 3'd3;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_pos, w_pos_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [6:0] r_led, w_led_nxt;
    logic [1:0] r_winner, w_winner_nxt;
    logic       r_ready, w_ready_nxt;
    logic       r_pbl_q, r_pbr_q;

    logic       w_rise_l, w_rise_r, w_move_l, w_move_r;
    logic [6:0] w_end_led;

    assign w_rise_l  = pbl & ~r_pbl_q;
    assign w_rise_r  = pbr & ~r_pbr_q;
    // In PLAY, r_cnt doubles as the lockout countdown; a tie is never a move.
    assign w_move_l  = w_rise_l & ~w_rise_r & (r_cnt == 8'd0);
    assign w_move_r  = w_rise_r & ~w_rise_l & (r_cnt == 8'd0);
    assign w_end_led = (r_state == WIN_L) ? 7'b1000000 : 7'b0000001;

    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_cnt_nxt    = r_cnt;
        w_led_nxt    = r_led;
        w_winner_nxt = r_winner;
        w_ready_nxt  = r_ready;
        case (r_state)
            RST_SHOW: begin
                w_state_nxt  = BLANK;
                w_pos_nxt    = POS_START;
                w_cnt_nxt    = 8'd0;
                w_led_nxt    = 7'b0000000;
                w_winner_nxt = 2'b00;
                w_ready_nxt  = 1'b0;
            end
            BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = PLAY;
                    w_cnt_nxt   = 8'd0;
                    w_pos_nxt   = POS_START;
                    w_led_nxt   = 7'b0001000;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            PLAY: begin
                if (w_move_l || w_move_r) begin
                    if (w_move_l) w_pos_nxt = (r_pos == 3'd6) ? 3'd6 : r_pos + 3'd1;
                    else          w_pos_nxt = (r_pos == 3'd0) ? 3'd0 : r_pos - 3'd1;
                    w_led_nxt = 7'(7'b0000001 << w_pos_nxt);
                    w_cnt_nxt = LOCK_LOAD;
                    if (w_pos_nxt == 3'd6 || w_pos_nxt == 3'd0) begin
                        w_state_nxt  = (w_pos_nxt == 3'd6) ? WIN_L : WIN_R;
                        w_winner_nxt = (w_pos_nxt == 3'd6) ? 2'b10 : 2'b01;
                        w_ready_nxt  = 1'b0;
                        w_cnt_nxt    = 8'd0;
                    end
                end else if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            WIN_L, WIN_R: begin
                // Terminal: only the flash timer runs until reset.
                if (r_cnt == FLASH_LAST) begin
                    w_cnt_nxt = 8'd0;
                    w_led_nxt = (r_led == 7'b0000000) ? w_end_led : 7'b0000000;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = RST_SHOW;
                w_led_nxt   = 7'b1111111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RST_SHOW;
            r_pos    <= POS_START;
            r_cnt    <= 8'd0;
            r_led    <= 7'b1111111;
            r_winner <= 2'b00;
            r_ready  <= 1'b0;
            r_pbl_q  <= 1'b0;
            r_pbr_q  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_cnt    <= w_cnt_nxt;
            r_led    <= w_led_nxt;
            r_winner <= w_winner_nxt;
            r_ready  <= w_ready_nxt;
            r_pbl_q  <= pbl;
            r_pbr_q  <= pbr;
        end
    end

    assign led_out = r_led;
    assign winner  = r_winner;
    assign ready   = r_ready;

endmodule
